mole_box_picker: RTL and testbench

- Parametrised random box selector for the whack-a-mole game.
- Wraps an N-bit XNOR Fibonacci LFSR. Maps LFSR states uniformly onto NUM_BOXES target boxes using rejection sampling, with a bounded retry count.
- Delivers each pick to the game FSM over a req/ready, valid/ack handshake.
- Successor to the fixed 3-bit, non-uniform box generator; sits between the game controller and the box display/hit logic.

---
 rtl/mole_pkg.sv | 38 +++
 rtl/mole_lfsr.sv | 45 ++++
 rtl/mole_box_picker.sv | 139 +++++++++++++
 tb/tb_mole_box_picker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: shared types and helpers for the whack-a-mole box picker.
// Holds the LFSR tap table, index-width helper and picker state enum.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    HOLD
  } pick_state_e;

  // Maximal-length XNOR tap masks, bit i set means lfsr[i] is tapped.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0006;
    endcase
    return t;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: Fibonacci XNOR LFSR with load, advance and lock-up guard.
// A load of all-ones is replaced by SEED so the register never locks up.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [15:0]      TAPS16 = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic             fb;

  always_comb begin
    fb     = ~^(lfsr_q & TAPS);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (&load_val) ? SEED_V : load_val;
    end else if (advance) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED_V;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/mole_box_picker.sv
// mole_box_picker: uniform random box selector via LFSR rejection sampling.
// Define MOLE_NO_REPEAT_EN to forbid consecutive identical picks.
module mole_box_picker
  import mole_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_BOXES = 4,
  parameter int SEED      = 1,
  parameter int MAX_TRIES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        req,
  output logic                        ready,
  output logic                        valid,
  input  logic                        ack,
  output logic [idx_w(NUM_BOXES)-1:0] box,
  input  logic                        seed_load,
  input  logic [WIDTH-1:0]            seed_in,
  output logic [WIDTH-1:0]            lfsr_state
);

  localparam int IDX_W = idx_w(NUM_BOXES);
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [IDX_W:0]   NB       = (IDX_W + 1)'(NUM_BOXES);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  pick_state_e      state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [IDX_W-1:0] box_q, box_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             have_last_q, have_last_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;

  logic             advance;
  logic             accept;
  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   last_inc;
  logic [IDX_W-1:0] fallback;

  mole_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .advance  (advance),
    .state    (lfsr_state)
  );

  assign cand     = lfsr_state[IDX_W-1:0];
  assign last_inc = {1'b0, last_q} + 1'b1;

  always_comb begin
    fallback = '0;
    if (have_last_q && (last_inc != NB)) begin
      fallback = last_inc[IDX_W-1:0];
    end
`ifdef MOLE_NO_REPEAT_EN
    accept = ({1'b0, cand} < NB) &&
             !(have_last_q && (cand == last_q));
`else
    accept = ({1'b0, cand} < NB);
`endif
  end

  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    box_d       = box_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: begin
        advance = enable;
        if (req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        advance = 1'b1;
        if (accept) begin
          box_d       = cand;
          last_d      = cand;
          have_last_d = 1'b1;
          state_d     = HOLD;
        end else if (tries_q == TRY_LAST) begin
          box_d       = fallback;
          last_d      = fallback;
          have_last_d = 1'b1;
          state_d     = HOLD;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      HOLD: begin
        advance = enable;
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tries_q     <= '0;
      box_q       <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      box_q       <= box_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign box   = box_q;

endmodule

// File: tb/tb_mole_box_picker.sv
// tb_mole_box_picker: four picker configurations driven in lockstep.
// Directed table of picks plus random traffic against a behavioural model.
module tb_mole_box_picker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       req;
  logic       ack;
  logic       seed_load;
  logic [7:0] seed_in;

  logic [3:0] rdy;
  logic [3:0] vld;
  logic [1:0] box_a_o, box_b_o, box_c_o;
  logic [2:0] box_d_o;
  logic [2:0] ls_a, ls_b, ls_c;
  logic [7:0] ls_d;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mole_box_picker #(.WIDTH(3), .NUM_BOXES(4), .SEED(1), .MAX_TRIES(16)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .ready(rdy[0]), .valid(vld[0]), .ack(ack), .box(box_a_o),
    .seed_load(seed_load), .seed_in(seed_in[2:0]), .lfsr_state(ls_a));

  mole_box_picker #(.WIDTH(3), .NUM_BOXES(3), .SEED(1), .MAX_TRIES(16)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .ready(rdy[1]), .valid(vld[1]), .ack(ack), .box(box_b_o),
    .seed_load(seed_load), .seed_in(seed_in[2:0]), .lfsr_state(ls_b));

  mole_box_picker #(.WIDTH(3), .NUM_BOXES(3), .SEED(1), .MAX_TRIES(1)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .ready(rdy[2]), .valid(vld[2]), .ack(ack), .box(box_c_o),
    .seed_load(seed_load), .seed_in(seed_in[2:0]), .lfsr_state(ls_c));

  mole_box_picker #(.WIDTH(8), .NUM_BOXES(5), .SEED(1), .MAX_TRIES(3)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .ready(rdy[3]), .valid(vld[3]), .ack(ack), .box(box_d_o),
    .seed_load(seed_load), .seed_in(seed_in), .lfsr_state(ls_d));

  int P_W[4]  = '{3, 3, 3, 8};
  int P_N[4]  = '{4, 3, 3, 5};
  int P_MT[4] = '{16, 16, 1, 3};
`ifdef MOLE_NO_REPEAT_EN
  int no_rep = 1;
`else
  int no_rep = 0;
`endif

  // Behavioural model: 0 = waiting, 1 = drawing, 2 = holding a pick.
  int m_lfsr[4], m_phase[4], m_tries[4], m_box[4], m_last[4], m_have[4];

  function automatic int get_box(int k);
    case (k)
      0: return int'(box_a_o);
      1: return int'(box_b_o);
      2: return int'(box_c_o);
      default: return int'(box_d_o);
    endcase
  endfunction

  function automatic int get_lfsr(int k);
    case (k)
      0: return int'(ls_a);
      1: return int'(ls_b);
      2: return int'(ls_c);
      default: return int'(ls_d);
    endcase
  endfunction

  function automatic int lfsr_next(int w, int s);
    int t[4];
    int nt;
    int fb;
    if (w == 3) begin
      t = '{3, 2, 0, 0};
      nt = 2;
    end else begin
      t = '{8, 6, 5, 4};
      nt = 4;
    end
    fb = 1;
    for (int i = 0; i < nt; i++) fb = fb ^ ((s >> (t[i] - 1)) & 1);
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int mask, nb, cand, ok, adv, ld;
      if (reset) begin
        m_lfsr[k] = 1; m_phase[k] = 0; m_tries[k] = 0;
        m_box[k] = 0; m_last[k] = 0; m_have[k] = 0;
      end else begin
        mask = (1 << P_W[k]) - 1;
        nb   = (P_N[k] <= 2) ? 1 : $clog2(P_N[k]);
        cand = m_lfsr[k] % (1 << nb);
        adv  = (m_phase[k] == 1) || enable;
        if (m_phase[k] == 0) begin
          if (req) begin
            m_phase[k] = 1;
            m_tries[k] = 0;
          end
        end else if (m_phase[k] == 1) begin
          ok = (cand < P_N[k]) &&
               !(no_rep != 0 && m_have[k] != 0 && cand == m_last[k]);
          if (ok == 0 && m_tries[k] + 1 >= P_MT[k]) begin
            cand = (m_have[k] != 0) ? (m_last[k] + 1) % P_N[k] : 0;
            ok = 1;
          end
          if (ok != 0) begin
            m_box[k] = cand; m_last[k] = cand; m_have[k] = 1;
            m_phase[k] = 2;
          end else begin
            m_tries[k]++;
          end
        end else if (ack) begin
          m_phase[k] = 0;
        end
        if (seed_load) begin
          ld = int'(seed_in) & mask;
          m_lfsr[k] = (ld == mask) ? 1 : ld;
        end else if (adv != 0) begin
          m_lfsr[k] = lfsr_next(P_W[k], m_lfsr[k]);
        end
      end
    end
  endtask

  task automatic chk(string nm, int k, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d got=%0d exp=%0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("ready", k, int'(rdy[k]), (m_phase[k] == 0) ? 1 : 0);
      chk("valid", k, int'(vld[k]), (m_phase[k] == 2) ? 1 : 0);
      chk("box",   k, get_box(k), m_box[k]);
      chk("lfsr",  k, get_lfsr(k), m_lfsr[k]);
    end
  endtask

  int pk_dr[4];
  int pk_bx[4];

  task automatic pick(input int hold, input int hold_box);
    int left;
    pk_dr = '{-1, -1, -1, -1};
    pk_bx = '{-1, -1, -1, -1};
    req = 1'b1;
    tick();
    req = 1'b0;
    left = 4;
    for (int c = 1; c <= 40 && left > 0; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (pk_dr[k] < 0 && vld[k]) begin
          pk_dr[k] = c;
          pk_bx[k] = get_box(k);
          left--;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (pk_dr[k] < 0) chk("pick_timeout", k, 0, 1);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_box", 0, get_box(0), hold_box);
      chk("hold_valid", 0, int'(vld[0]), 1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 4; k++) chk("ack_ready", k, int'(rdy[k]), 1);
  endtask

  typedef struct {
    int a_box; int a_dr;
    int b_box; int b_dr;
    int c_box; int c_dr;
  } pick_vec_t;

  pick_vec_t tbl[7];
  int seq[8];

  initial begin
    tbl[0] = '{1, 1,  1,  1,  1,  1};
    tbl[1] = '{3, 1,  2,  2,  2,  1};
    tbl[2] = '{2, 1, -1, -1, -1, -1};
    tbl[3] = '{1, 1, -1, -1, -1, -1};
    tbl[4] = '{2, 1, -1, -1, -1, -1};
    tbl[5] = '{0, 1, -1, -1, -1, -1};
    if (no_rep != 0) tbl[6] = '{1, 2, -1, -1, -1, -1};
    else             tbl[6] = '{0, 1, -1, -1, -1, -1};
    seq = '{3, 6, 5, 2, 4, 0, 1, 3};

    reset = 1'b1; enable = 1'b0; req = 1'b0; ack = 1'b0;
    seed_load = 1'b0; seed_in = '0;
    tick();
    tick();
    chk("rst_ready", 0, int'(rdy[0]), 1);
    chk("rst_valid", 0, int'(vld[0]), 0);
    chk("rst_box",   0, get_box(0), 0);
    chk("rst_lfsr",  0, get_lfsr(0), 1);

    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("seq", 0, get_lfsr(0), seq[i]);
    end

    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int p = 0; p < 7; p++) begin
      pick((p == 0) ? 5 : 0, tbl[p].a_box);
      chk("pick_a_box", 0, pk_bx[0], tbl[p].a_box);
      chk("pick_a_draws", 0, pk_dr[0], tbl[p].a_dr);
      if (tbl[p].b_box >= 0) begin
        chk("pick_b_box", 1, pk_bx[1], tbl[p].b_box);
        chk("pick_b_draws", 1, pk_dr[1], tbl[p].b_dr);
        chk("pick_c_box", 2, pk_bx[2], tbl[p].c_box);
        chk("pick_c_draws", 2, pk_dr[2], tbl[p].c_dr);
      end
      tick();
    end

    seed_load = 1'b1; seed_in = 8'hFF;
    tick();
    seed_load = 1'b0;
    chk("seed_guard", 0, get_lfsr(0), 1);
    chk("seed_guard", 3, get_lfsr(3), 1);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("draw_ready", 0, int'(rdy[0]), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", 0, int'(rdy[0]), 1);
    chk("abort_valid", 0, int'(vld[0]), 0);
    chk("abort_box",   0, get_box(0), 0);

    for (int i = 0; i < 3000; i++) begin
      enable    = 1'($urandom_range(1, 0));
      req       = ($urandom_range(2, 0) == 0);
      ack       = ($urandom_range(2, 0) == 0);
      seed_load = ($urandom_range(39, 0) == 0);
      seed_in   = 8'($urandom);
      reset     = ($urandom_range(199, 0) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
